// File: rtl/lane_paint_pkg.sv
// Shared types and helpers for the drum-lane painter.
//
// Contents:
//   state_e        : painter FSM state encoding (IDLE, ARMED, STATIC, LANE, HOLD)
//   MAX_LANES      : widest lane vector the helper function accepts
//   LSB_W          : width of the index returned by lowest_set_bit()
//   lowest_set_bit : index of the lowest set bit of a vector (0 when none set)
package lane_paint_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_STATIC = 3'd2,
        ST_LANE   = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    localparam int unsigned MAX_LANES = 32;
    localparam int unsigned LSB_W     = 5;

    // Scan from the top down so the last match written is the lowest index.
    function automatic logic [LSB_W-1:0] lowest_set_bit(input logic [MAX_LANES-1:0] vec);
        lowest_set_bit = '0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set_bit = LSB_W'(i);
        end
    endfunction

endpackage

// File: rtl/lane_prio_enc.sv
// Lowest-index priority encoder for the drum hit vector.
//
// Ports:
//   req_i   [LANES]          : request vector, bit i = lane i
//   idx_o   [$clog2(LANES)]  : index of the lowest set request (0 when none)
//   valid_o                  : at least one request is set
//
// LANES must not exceed lane_paint_pkg::MAX_LANES.
module lane_prio_enc
    import lane_paint_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic [LANES-1:0]         req_i,
    output logic [$clog2(LANES)-1:0] idx_o,
    output logic                     valid_o
);

    logic [MAX_LANES-1:0] req_wide;

    assign req_wide = MAX_LANES'(req_i);
    assign idx_o    = $clog2(LANES)'(lowest_set_bit(req_wide));
    assign valid_o  = |req_i;

endmodule

// File: rtl/lane_paint_fsm.sv
// Drum-lane painter: paints the lane of the most recent drum hit, keeps it
// painted for HOLD_CYCLES after release, or paints a static band on request.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   start      : arm painting from IDLE (clears hit_count)
//   stop       : return to IDLE from any state, highest priority
//   static_req : request the static band
//   hit        : per-lane drum hit levels, bit i = lane i
//   lane_on    : one-hot painted lane, 0 when none
//   static_on  : static band painted
//   active     : high in every state except IDLE
//   hit_count  : LANE entries since last start, saturating
//
// All outputs are decoded from registers only.
module lane_paint_fsm
    import lane_paint_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               static_req,
    input  logic [LANES-1:0]   hit,
    output logic [LANES-1:0]   lane_on,
    output logic               static_on,
    output logic               active,
    output logic [COUNT_W-1:0] hit_count
);

    localparam int unsigned IDX_W  = $clog2(LANES);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    // Counter runs HOLD_CYCLES-1 .. 0, giving exactly HOLD_CYCLES painted cycles.
    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0]   hit_idx;
    logic               hit_valid;
    logic               enter_lane;

    lane_prio_enc #(.LANES(LANES)) u_prio_enc (
        .req_i   (hit),
        .idx_o   (hit_idx),
        .valid_o (hit_valid)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        enter_lane = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end
                end
                ST_ARMED: begin
                    if (hit_valid)       enter_lane = 1'b1;
                    else if (static_req) state_d    = ST_STATIC;
                end
                ST_STATIC: begin
                    if (hit_valid)        enter_lane = 1'b1;
                    else if (!static_req) state_d    = ST_ARMED;
                end
                ST_LANE: begin
                    // Only the latched lane matters here; other lanes are ignored.
                    if (!hit[sel_q]) begin
                        if (HOLD_CYCLES == 0) begin
                            state_d = ST_ARMED;
                        end else begin
                            state_d = ST_HOLD;
                            hold_d  = HOLD_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hit_valid)          enter_lane = 1'b1;
                    else if (hold_q == '0)  state_d    = ST_ARMED;
                    else                    hold_d     = hold_q - HOLD_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Shared LANE entry path: latch the lowest hit lane and count the entry.
        if (enter_lane) begin
            state_d = ST_LANE;
            sel_d   = hit_idx;
            if (cnt_q != '1) cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lane_on   = (state_q == ST_LANE || state_q == ST_HOLD)
                       ? (LANES'(1) << sel_q) : '0;
    assign static_on = (state_q == ST_STATIC);
    assign active    = (state_q != ST_IDLE);
    assign hit_count = cnt_q;

endmodule

// File: tb/tb_lane_paint_fsm.sv
// Scoreboard bench for lane_paint_fsm. One input stream drives two instances:
// dut (COUNT_W=16) and dut_sat (COUNT_W=2, saturates at 3). Each stimulus
// cycle pushes the outputs expected after that clock edge; a monitor pops and
// compares one entry per cycle, #1 after the rising edge.
module tb_lane_paint_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        static_req = 1'b0;
    logic [3:0]  hit = '0;

    logic [3:0]  lane_on,   lane_on2;
    logic        static_on, static_on2;
    logic        active,    active2;
    logic [15:0] hit_count;
    logic [1:0]  hit_count2;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    typedef struct {
        logic [3:0] lane;
        logic       stat;
        logic       act;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    lane_paint_fsm #(.LANES(4), .HOLD_CYCLES(3), .COUNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .static_req (static_req),
        .hit        (hit),
        .lane_on    (lane_on),
        .static_on  (static_on),
        .active     (active),
        .hit_count  (hit_count)
    );

    lane_paint_fsm #(.LANES(4), .HOLD_CYCLES(3), .COUNT_W(2)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .static_req (static_req),
        .hit        (hit),
        .lane_on    (lane_on2),
        .static_on  (static_on2),
        .active     (active2),
        .hit_count  (hit_count2)
    );

    task automatic check(input string name, input int cyc,
                         input logic [31:0] act_v, input logic [31:0] req_v);
        n_tests++;
        if (act_v !== req_v) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act_v, req_v);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic st, input logic sp, input logic sr,
                       input logic [3:0] h, input logic [3:0] el, input logic es,
                       input logic ea, input int ec);
        exp_t e;
        @(negedge clk);
        reset      = r;
        start      = st;
        stop       = sp;
        static_req = sr;
        hit        = h;
        e.lane = el;
        e.stat = es;
        e.act  = ea;
        e.cnt  = ec;
        exp_q.push_back(e);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        int   sat;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                sat = (e.cnt > 3) ? 3 : e.cnt;
                n_cyc++;
                check("lane_on",    n_cyc, 32'(lane_on),    32'(e.lane));
                check("static_on",  n_cyc, 32'(static_on),  32'(e.stat));
                check("active",     n_cyc, 32'(active),     32'(e.act));
                check("hit_count",  n_cyc, 32'(hit_count),  32'(e.cnt));
                check("sat_lane",   n_cyc, 32'(lane_on2),   32'(e.lane));
                check("sat_active", n_cyc, 32'(active2),    32'(e.act));
                check("sat_count",  n_cyc, 32'(hit_count2), 32'(sat));
            end
        end
    end

    // Stimulus: r st sp sr hit | lane stat act cnt
    initial begin
        // reset state
        cyc(1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        cyc(1, 1, 0, 1, 4'b1111, 4'b0000, 0, 0, 0);
        // start -> ARMED; hit lane 2 for two cycles, then 3 hold cycles
        cyc(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
        cyc(0, 0, 0, 0, 4'b0100, 4'b0100, 0, 1, 1);
        cyc(0, 0, 0, 0, 4'b0100, 4'b0100, 0, 1, 1);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0100, 0, 1, 1);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0100, 0, 1, 1);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0100, 0, 1, 1);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 1);
        // multi-hit picks lowest lane; other lanes ignored while in LANE
        cyc(0, 0, 0, 0, 4'b1010, 4'b0010, 0, 1, 2);
        cyc(0, 0, 0, 0, 4'b1011, 4'b0010, 0, 1, 2);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0010, 0, 1, 2);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0010, 0, 1, 2);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0010, 0, 1, 2);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 2);
        // lane 0, release, retrigger to lane 3 with hold_cnt=1
        cyc(0, 0, 0, 0, 4'b0001, 4'b0001, 0, 1, 3);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 3);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 3);
        cyc(0, 0, 0, 0, 4'b1000, 4'b1000, 0, 1, 4);
        // retrigger on the same lane from HOLD
        cyc(0, 0, 0, 0, 4'b0000, 4'b1000, 0, 1, 4);
        cyc(0, 0, 0, 0, 4'b1000, 4'b1000, 0, 1, 5);
        cyc(0, 0, 0, 0, 4'b0000, 4'b1000, 0, 1, 5);
        cyc(0, 0, 0, 0, 4'b0000, 4'b1000, 0, 1, 5);
        cyc(0, 0, 0, 0, 4'b0000, 4'b1000, 0, 1, 5);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 5);
        // static band for 5 cycles, then a hit takes over
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 4'b0000, 4'b0000, 1, 1, 5);
        cyc(0, 0, 0, 1, 4'b0001, 4'b0001, 0, 1, 6);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 6);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 6);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 6);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 6);
        // STATIC with static_req dropped returns to ARMED
        cyc(0, 0, 0, 1, 4'b0000, 4'b0000, 1, 1, 6);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 6);
        // start outside IDLE does not clear the count
        cyc(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 6);
        // stop mid-LANE with hit held; start during LANE ignored
        cyc(0, 0, 0, 0, 4'b0100, 4'b0100, 0, 1, 7);
        cyc(0, 1, 0, 0, 4'b0100, 4'b0100, 0, 1, 7);
        cyc(0, 0, 1, 0, 4'b0100, 4'b0000, 0, 0, 7);
        cyc(0, 0, 0, 1, 4'b0100, 4'b0000, 0, 0, 7);
        // stop wins over start; then start clears the count
        cyc(0, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 7);
        cyc(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
        // reset mid-HOLD clears everything next cycle
        cyc(0, 0, 0, 0, 4'b0010, 4'b0010, 0, 1, 1);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0010, 0, 1, 1);
        cyc(1, 1, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
        cyc(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check("drain", n_cyc, 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
